axi_sram_lat: RTL and testbench
===============================

// Module: axi_sram_lat
// PURPOSE
//  AXI4-Lite slave backed by a local word-addressed SRAM array. Generalised successor of the
//  single-cycle SRAM slave: it adds a configurable data width and depth, programmable or
//  pseudo-random read/write latency, and accepts AW and W in either order.
//  It returns SLVERR for out-of-range addresses. It sits behind the IFU/LSU AXI masters and the arbiter in simulation.
// PARAMETERS
//  ADDR_W      32            address width
//  DATA_W      32            data width; 32 or 64; STRB_W = DATA_W/8
//  DEPTH       1024          number of DATA_W words in the array
//  BASE_ADDR   32'h8000_0000 byte address of word 0
//  RD_LAT      1             extra wait cycles before rvalid, 0..15
//  WR_LAT      1             extra wait cycles before bvalid, 0..15
//  RAND_DELAY  0             1: add (lfsr[2:0]) cycles to every latency
//  LFSR_SEED   8'hA5         LFSR reset value; must be nonzero
// PORTS
//  aclk     in   1        clock
//  aresetn  in   1        asynchronous active-low reset
//  araddr   in   ADDR_W   read address
//  arvalid  in   1        read address valid
//  arready  out  1        read address ready
//  rdata    out  DATA_W   read data
//  rresp    out  2        read response: 00 OKAY, 10 SLVERR
//  rvalid   out  1        read data valid
//  rready   in   1        read data ready
//  awaddr   in   ADDR_W   write address
//  awvalid  in   1        write address valid
//  awready  out  1        write address ready
//  wdata    in   DATA_W   write data
//  wstrb    in   STRB_W   byte enables; bit i enables wdata[8i+7:8i]
//  wvalid   in   1        write data valid
//  wready   out  1        write data ready
//  bresp    out  2        write response: 00 OKAY, 10 SLVERR
//  bvalid   out  1        write response valid
//  bready   in   1        write response ready
// BEHAVIOUR
//  Reset: all outputs are 0 while aresetn is low, including the readies. The readies rise at the first posedge after release.
//   The LFSR loads LFSR_SEED. The array is NOT cleared. A reset mid-transaction drops the transaction with no response.
//  Index: idx = (addr - BASE_ADDR) >> log2(STRB_W). Low address bits are ignored.
//   The address is in range iff BASE_ADDR <= addr < BASE_ADDR + DEPTH*STRB_W.
//  Read FSM R_IDLE -> R_WAIT -> R_RESP:
//   R_IDLE: arready=1. On arvalid&arready the FSM latches araddr and loads rcnt = RD_LAT (+rand).
//     It goes to R_RESP if rcnt==0, otherwise to R_WAIT.
//   R_WAIT: arready=0. rcnt decrements each cycle; at 1 -> R_RESP.
//   On the edge entering R_RESP: rdata <= mem[idx] and rresp <= OKAY; out of range: rdata <= 0, rresp <= SLVERR.
//   R_RESP: rvalid=1. rdata and rresp are held stable until rready. On rvalid&rready -> R_IDLE and rvalid <= 0.
//   Latency: AR handshake at edge T gives rvalid high from T+1+lat. Minimum is 2 cycles per read.
//  Write FSM W_IDLE -> W_WAIT -> W_RESP:
//   W_IDLE: awready=1 until AW is captured and wready=1 until W is captured, independently. Each drops after its own handshake.
//     When both are held (same or different cycles) the FSM loads wcnt = WR_LAT (+rand).
//     It goes to W_RESP if wcnt==0, otherwise to W_WAIT.
//   On the edge entering W_RESP: in range, mem[idx] bytes with wstrb=1 are updated; out of range, no write and bresp <= SLVERR.
//   W_RESP: bvalid=1 until bready. Then -> W_IDLE and both readies re-assert the next cycle.
//  Simultaneous read/write commit to the same idx on one edge: the read returns OLD data (read-first).
//  Read and write paths are fully independent. No ordering is enforced between them.
//  wstrb=0 in range: the array is unchanged and bresp=OKAY.
//  LFSR: 8-bit Fibonacci, taps 8,6,5,4. It advances every cycle and is sampled at load time. Counters are 5 bits wide.
// STRUCTURE
//  axi_sram_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, read/write state enums, LFSR taps.
//  Sub-module axi_sram_lfsr (seed param; ports aclk, aresetn, out[7:0]) is shared by both paths.
//  Everything else (two FSMs, counters, array, range check) lives in axi_sram_lat.
// TESTING
//  1 Write 32'hDEADBEEF@0x8000_0010 with wstrb=F, WR_LAT=1 -> bvalid 2 cycles after the W handshake, bresp=00.
//    Read back with RD_LAT=1 -> rvalid 2 cycles after AR, rdata=DEADBEEF.
//  2 W given 3 cycles before AW (wdata=0x11223344, wstrb=4'b0101) onto a word holding 0xDEADBEEF -> readback 0xDE22BE44.
//  3 araddr=0x7FFF_FFFC and awaddr=BASE+DEPTH*4 -> rresp=10, rdata=0, bresp=10; array unchanged.
//  4 Hold rready=0 and bready=0 for 5 cycles -> rvalid, rdata, bvalid, bresp stable; arready and awready stay 0.
//  5 Read and write commit to the same word on the same edge (RD_LAT=WR_LAT=0) -> rdata=old value; a later read gives the new value.
//  6 Drop aresetn during R_WAIT and W_WAIT -> all outputs 0 immediately.
//    After release: readies high next cycle, no stale rvalid/bvalid, earlier array contents intact.
//    Run with RAND_DELAY=1: latencies fall in 1..8 and every response still matches a scoreboard.

Source files
------------

// File: rtl/axi_sram_pkg.sv
// Shared constants and state types for the latency-modelling AXI4-Lite SRAM slave.
package axi_sram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Fibonacci taps 8,6,5,4 (bit 7 is tap 8)
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_e;

endpackage

// File: rtl/axi_sram_lfsr.sv
// Free-running 8-bit Fibonacci LFSR that supplies extra latency to both channels.
module axi_sram_lfsr
    import axi_sram_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       aclk,
    input  logic       aresetn,
    output logic [7:0] out
);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) out <= SEED;
        else          out <= {out[6:0], ^(out & LFSR_TAPS)};
    end

endmodule

// File: rtl/axi_sram_lat.sv
// AXI4-Lite slave over a word-addressed array with programmable or pseudo-random
// read/write latency; AW and W may arrive in any order.
module axi_sram_lat
    import axi_sram_pkg::*;
#(
    parameter int              ADDR_W     = 32,
    parameter int              DATA_W     = 32,
    parameter int              DEPTH      = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int              RD_LAT     = 1,
    parameter int              WR_LAT     = 1,
    parameter int              RAND_DELAY = 0,
    parameter logic [7:0]      LFSR_SEED  = 8'hA5,
    localparam int             STRB_W     = DATA_W / 8
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready
);

    localparam int              OFF_W = $clog2(STRB_W);
    localparam int              IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] SPAN  = (ADDR_W + 1)'(DEPTH * STRB_W);
    localparam logic [ADDR_W:0] LIMIT = {1'b0, BASE_ADDR} + SPAN;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < LIMIT);
    endfunction

    function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> OFF_W);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    // Readies stay low until the first edge after reset release
    logic rst_done;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rst_done <= 1'b0;
        else          rst_done <= 1'b1;
    end

    logic [7:0] lfsr;
    axi_sram_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .aclk    (aclk),
        .aresetn (aresetn),
        .out     (lfsr)
    );

    logic [4:0] rnd_add, rd_ld, wr_ld;
    assign rnd_add = (RAND_DELAY != 0) ? 5'(lfsr & 8'h07) : 5'd0;
    assign rd_ld   = 5'(RD_LAT) + rnd_add;
    assign wr_ld   = 5'(WR_LAT) + rnd_add;

    // ---------------- read channel ----------------
    rd_state_e         rstate, rstate_n;
    logic [4:0]        rcnt;
    logic [ADDR_W-1:0] raddr, rd_src;
    logic              ar_hs, rd_commit;

    always_comb begin
        rstate_n = rstate;
        arready  = 1'b0;
        rvalid   = 1'b0;
        ar_hs    = 1'b0;
        case (rstate)
            R_IDLE: begin
                arready = rst_done;
                ar_hs   = arvalid & rst_done;
                if (ar_hs) rstate_n = (rd_ld == 5'd0) ? R_RESP : R_WAIT;
            end
            R_WAIT: if (rcnt == 5'd1) rstate_n = R_RESP;
            R_RESP: begin
                rvalid = 1'b1;
                if (rready) rstate_n = R_IDLE;
            end
            default: rstate_n = R_IDLE;
        endcase
    end

    assign rd_commit = (rstate != R_RESP) && (rstate_n == R_RESP);
    // Zero-latency reads commit on the AR edge, before raddr holds the address
    assign rd_src    = (rstate == R_IDLE) ? araddr : raddr;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rstate <= R_IDLE;
            rcnt   <= 5'd0;
            raddr  <= '0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
        end else begin
            rstate <= rstate_n;
            if (ar_hs) begin
                raddr <= araddr;
                rcnt  <= rd_ld;
            end else if (rstate == R_WAIT) begin
                rcnt <= rcnt - 5'd1;
            end
            if (rd_commit) begin
                if (in_range(rd_src)) begin
                    rdata <= mem[to_idx(rd_src)];
                    rresp <= RESP_OKAY;
                end else begin
                    rdata <= '0;
                    rresp <= RESP_SLVERR;
                end
            end
        end
    end

    // ---------------- write channel ----------------
    wr_state_e         wstate, wstate_n;
    logic [4:0]        wcnt;
    logic              aw_held, w_held, aw_hs, w_hs, wr_commit;
    logic [ADDR_W-1:0] waddr_q, wa_src;
    logic [DATA_W-1:0] wdata_q, wd_src;
    logic [STRB_W-1:0] wstrb_q, ws_src;

    always_comb begin
        wstate_n = wstate;
        awready  = 1'b0;
        wready   = 1'b0;
        bvalid   = 1'b0;
        aw_hs    = 1'b0;
        w_hs     = 1'b0;
        case (wstate)
            W_IDLE: begin
                awready = rst_done & ~aw_held;
                wready  = rst_done & ~w_held;
                aw_hs   = awvalid & awready;
                w_hs    = wvalid & wready;
                if ((aw_held | aw_hs) && (w_held | w_hs))
                    wstate_n = (wr_ld == 5'd0) ? W_RESP : W_WAIT;
            end
            W_WAIT: if (wcnt == 5'd1) wstate_n = W_RESP;
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) wstate_n = W_IDLE;
            end
            default: wstate_n = W_IDLE;
        endcase
    end

    assign wr_commit = (wstate != W_RESP) && (wstate_n == W_RESP);
    // Whichever half arrives on the committing edge is taken straight from the bus
    assign wa_src    = aw_held ? waddr_q : awaddr;
    assign wd_src    = w_held  ? wdata_q : wdata;
    assign ws_src    = w_held  ? wstrb_q : wstrb;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wstate  <= W_IDLE;
            wcnt    <= 5'd0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            bresp   <= RESP_OKAY;
        end else begin
            wstate <= wstate_n;
            if (aw_hs) begin
                waddr_q <= awaddr;
                aw_held <= 1'b1;
            end
            if (w_hs) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb;
                w_held  <= 1'b1;
            end
            if (wstate == W_IDLE && wstate_n != W_IDLE) wcnt <= wr_ld;
            else if (wstate == W_WAIT)                  wcnt <= wcnt - 5'd1;
            if (bvalid && bready) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
            if (wr_commit) bresp <= in_range(wa_src) ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Array is not reset; same-edge read commit sees the old word
    always_ff @(posedge aclk) begin
        if (wr_commit && in_range(wa_src)) begin
            for (int i = 0; i < STRB_W; i++)
                if (ws_src[i]) mem[to_idx(wa_src)][8*i +: 8] <= wd_src[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_axi_sram_lat.sv
// Bench for axi_sram_lat: fixed-latency instance for directed vectors, random-delay instance
// checked against a word-array model.
module tb_axi_sram_lat;

    localparam logic [1:0] OK  = 2'b00;
    localparam logic [1:0] ERR = 2'b10;

    logic aclk, aresetn;
    logic [1:0][31:0] araddr, rdata, awaddr, wdata;
    logic [1:0][3:0]  wstrb;
    logic [1:0][1:0]  rresp, bresp;
    logic [1:0]       arvalid, arready, rvalid, rready;
    logic [1:0]       awvalid, awready, wvalid, wready, bvalid, bready;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    // Instance 0: RD_LAT=WR_LAT=1 fixed; instance 1: same plus LFSR-driven extra delay
    for (genvar g = 0; g < 2; g++) begin : g_dut
        axi_sram_lat #(.RAND_DELAY(g)) u_dut (
            .aclk    (aclk),
            .aresetn (aresetn),
            .araddr  (araddr[g]),
            .arvalid (arvalid[g]),
            .arready (arready[g]),
            .rdata   (rdata[g]),
            .rresp   (rresp[g]),
            .rvalid  (rvalid[g]),
            .rready  (rready[g]),
            .awaddr  (awaddr[g]),
            .awvalid (awvalid[g]),
            .awready (awready[g]),
            .wdata   (wdata[g]),
            .wstrb   (wstrb[g]),
            .wvalid  (wvalid[g]),
            .wready  (wready[g]),
            .bresp   (bresp[g]),
            .bvalid  (bvalid[g]),
            .bready  (bready[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int v, input int lo, input int hi);
        tests++;
        if (v < lo || v > hi) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, v, lo, hi);
        end
    endtask

    task automatic tmo(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    task automatic do_write(input int k, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int aw_dly, input int w_dly,
                            input int hold, input logic [1:0] exp_r, input int lo, input int hi);
        int hs_aw, hs_w, hs;
        bit ok_aw, ok_w, got;
        hs_aw = 0; hs_w = 0; ok_aw = 0; ok_w = 0; got = 0;
        fork
            begin
                repeat (aw_dly + 1) @(posedge aclk);
                #1 awaddr[k] = a; awvalid[k] = 1'b1;
                for (int i = 0; i < 50 && !ok_aw; i++) begin
                    @(negedge aclk); ok_aw = awready[k];
                end
                if (!ok_aw) tmo("awready");
                @(posedge aclk); #1 awvalid[k] = 1'b0; hs_aw = cyc;
            end
            begin
                repeat (w_dly + 1) @(posedge aclk);
                #1 wdata[k] = d; wstrb[k] = s; wvalid[k] = 1'b1;
                for (int i = 0; i < 50 && !ok_w; i++) begin
                    @(negedge aclk); ok_w = wready[k];
                end
                if (!ok_w) tmo("wready");
                @(posedge aclk); #1 wvalid[k] = 1'b0; hs_w = cyc;
            end
        join
        hs = (hs_aw > hs_w) ? hs_aw : hs_w;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge aclk); got = bvalid[k];
        end
        if (!got) tmo("bvalid");
        else begin
            chk_rng("wr_lat", cyc - hs, lo, hi);
            chk("bresp", 32'(bresp[k]), 32'(exp_r));
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge aclk);
            chk1("b_hold_valid", bvalid[k], 1'b1);
            chk("b_hold_resp", 32'(bresp[k]), 32'(exp_r));
            chk1("b_hold_awready", awready[k], 1'b0);
        end
        bready[k] = 1'b1;
        @(posedge aclk); #1 bready[k] = 1'b0;
        @(negedge aclk);
        chk1("bvalid_clr", bvalid[k], 1'b0);
        chk1("awready_back", awready[k], 1'b1);
        chk1("wready_back", wready[k], 1'b1);
    endtask

    task automatic do_read(input int k, input logic [31:0] a, input int dly, input int hold,
                           input logic [31:0] exp_d, input logic [1:0] exp_r,
                           input int lo, input int hi);
        int hs;
        bit ok, got;
        ok = 0; got = 0;
        repeat (dly + 1) @(posedge aclk);
        #1 araddr[k] = a; arvalid[k] = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge aclk); ok = arready[k];
        end
        if (!ok) tmo("arready");
        @(posedge aclk); #1 arvalid[k] = 1'b0; hs = cyc;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge aclk); got = rvalid[k];
        end
        if (!got) tmo("rvalid");
        else begin
            chk_rng("rd_lat", cyc - hs, lo, hi);
            chk("rdata", rdata[k], exp_d);
            chk("rresp", 32'(rresp[k]), 32'(exp_r));
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge aclk);
            chk1("r_hold_valid", rvalid[k], 1'b1);
            chk("r_hold_data", rdata[k], exp_d);
            chk("r_hold_resp", 32'(rresp[k]), 32'(exp_r));
            chk1("r_hold_arready", arready[k], 1'b0);
        end
        rready[k] = 1'b1;
        @(posedge aclk); #1 rready[k] = 1'b0;
        @(negedge aclk);
        chk1("rvalid_clr", rvalid[k], 1'b0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        logic [1:0]  br;
        logic [31:0] rd;
        logic [1:0]  rr;
    } vec_t;

    vec_t        vt [8];
    logic [31:0] mdl [16];

    initial begin
        arvalid = '0; rready = '0; awvalid = '0; wvalid = '0; bready = '0;
        araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
        aresetn = 1'b0;

        vt[0] = '{32'h8000_0000, 32'hA5A5_5A5A, 4'hF, 2, 0, OK,  32'hA5A5_5A5A, OK};
        vt[1] = '{32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, OK,  32'hDEAD_BEEF, OK};
        vt[2] = '{32'h8000_0010, 32'h1122_3344, 4'h5, 3, 0, OK,  32'hDE22_BE44, OK};
        vt[3] = '{32'h8000_1000, 32'hCAFE_F00D, 4'hF, 0, 0, ERR, 32'h0,         ERR};
        vt[4] = '{32'h8000_0FFC, 32'h0BAD_C0DE, 4'hF, 1, 0, OK,  32'h0BAD_C0DE, OK};
        vt[5] = '{32'h8000_0FFF, 32'h1234_5678, 4'h8, 0, 1, OK,  32'h12AD_C0DE, OK};
        vt[6] = '{32'h7FFF_FFFC, 32'h1234_5678, 4'hF, 0, 0, ERR, 32'h0,         ERR};
        vt[7] = '{32'h8000_0012, 32'h0000_0000, 4'h0, 0, 0, OK,  32'hDE22_BE44, OK};

        // reset: everything low, readies only after first edge past release
        repeat (2) @(posedge aclk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk1("rst_arready", arready[k], 1'b0);
            chk1("rst_awready", awready[k], 1'b0);
            chk1("rst_wready", wready[k], 1'b0);
            chk1("rst_rvalid", rvalid[k], 1'b0);
            chk1("rst_bvalid", bvalid[k], 1'b0);
        end
        aresetn = 1'b1;
        @(negedge aclk);
        chk1("arready_pre_edge", arready[0], 1'b0);
        @(negedge aclk);
        chk1("arready_up", arready[0], 1'b1);
        chk1("awready_up", awready[0], 1'b1);

        for (int i = 0; i < 8; i++) begin
            do_write(0, vt[i].addr, vt[i].wd, vt[i].strb, vt[i].aw_dly, vt[i].w_dly, 0, vt[i].br, 1, 1);
            do_read(0, vt[i].addr, 0, 0, vt[i].rd, vt[i].rr, 1, 1);
        end
        // out-of-range writes must not alias onto the first or last word
        do_read(0, 32'h8000_0000, 0, 0, 32'hA5A5_5A5A, OK, 1, 1);
        do_read(0, 32'h8000_0FFC, 0, 0, 32'h12AD_C0DE, OK, 1, 1);

        // responses held under backpressure
        do_write(0, 32'h8000_0020, 32'h0F0F_0F0F, 4'hF, 0, 0, 5, OK, 1, 1);
        do_read(0, 32'h8000_0020, 0, 5, 32'h0F0F_0F0F, OK, 1, 1);

        // read and write commit on the same edge to the same word
        fork
            do_read(0, 32'h8000_0010, 0, 0, 32'hDE22_BE44, OK, 1, 1);
            do_write(0, 32'h8000_0010, 32'h5566_7788, 4'hF, 0, 0, 0, OK, 1, 1);
        join
        do_read(0, 32'h8000_0010, 0, 0, 32'h5566_7788, OK, 1, 1);

        // reset while both channels are waiting
        @(posedge aclk);
        #1 araddr[0] = 32'h8000_0020; arvalid[0] = 1'b1;
        awaddr[0] = 32'h8000_0010; wdata[0] = 32'hFFFF_FFFF; wstrb[0] = 4'hF;
        awvalid[0] = 1'b1; wvalid[0] = 1'b1;
        @(posedge aclk);
        #1 arvalid[0] = 1'b0; awvalid[0] = 1'b0; wvalid[0] = 1'b0;
        aresetn = 1'b0;
        #1;
        chk1("mid_arready", arready[0], 1'b0);
        chk1("mid_awready", awready[0], 1'b0);
        chk1("mid_wready", wready[0], 1'b0);
        chk1("mid_rvalid", rvalid[0], 1'b0);
        chk1("mid_bvalid", bvalid[0], 1'b0);
        chk("mid_rdata", rdata[0], 32'h0);
        chk("mid_rresp", 32'(rresp[0]), 32'h0);
        chk("mid_bresp", 32'(bresp[0]), 32'h0);
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(negedge aclk);
        chk1("rel_arready_pre", arready[0], 1'b0);
        @(negedge aclk);
        chk1("rel_arready", arready[0], 1'b1);
        chk1("rel_awready", awready[0], 1'b1);
        chk1("rel_wready", wready[0], 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            chk1("rel_no_rvalid", rvalid[0], 1'b0);
            chk1("rel_no_bvalid", bvalid[0], 1'b0);
        end
        do_read(0, 32'h8000_0010, 0, 0, 32'h5566_7788, OK, 1, 1);
        do_read(0, 32'h8000_0000, 0, 0, 32'hA5A5_5A5A, OK, 1, 1);

        // random traffic on the random-delay instance
        for (int i = 0; i < 16; i++) begin
            logic [31:0] d;
            d = $urandom;
            do_write(1, 32'h8000_0000 + 32'(4 * i), d, 4'hF,
                     $urandom_range(0, 2), $urandom_range(0, 2), 0, OK, 1, 8);
            mdl[i] = d;
        end
        for (int it = 0; it < 80; it++) begin
            int          j, off;
            bit          inr;
            logic [31:0] a, d;
            logic [3:0]  s;
            j   = $urandom_range(0, 17);
            off = $urandom_range(0, 3);
            inr = (j < 16);
            if (inr)          a = 32'h8000_0000 + 32'(4 * j + off);
            else if (j == 16) a = 32'h8000_1000 + 32'(off);
            else              a = 32'h7FFF_FFFC + 32'(off);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                do_write(1, a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), 0,
                         inr ? OK : ERR, 1, 8);
                if (inr)
                    for (int b = 0; b < 4; b++)
                        if (s[b]) mdl[j][8*b +: 8] = d[8*b +: 8];
            end else begin
                do_read(1, a, $urandom_range(0, 2), 0, inr ? mdl[j] : 32'h0,
                        inr ? OK : ERR, 1, 8);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
